operand_recover: RTL and testbench

Sequential inverse of the shared-subexpression arithmetic datapath. It accepts that datapath's sum, difference and product results (s1 = a+b, s5 = a−b, s2 = a*b, all mod 2^BW) and reconstructs the operand pair a, b. The block sits on the result side of the datapath as a self-check and decode stage. It uses a ready/valid handshake on both sides and one shared shift-add multiplier to test the two candidate operand pairs in turn.

---
 rtl/operand_recover_if.sv | 27 ++
 rtl/operand_recover.sv | 156 +++++++++++++++
 tb/tb_operand_recover.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_recover_if.sv
// Handshake bus for operand_recover: input triple channel and recovered-operand channel.
interface operand_recover_if #(
  parameter int unsigned BW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] s1;
  logic [BW-1:0] s5;
  logic [BW-1:0] s2;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] a_out;
  logic [BW-1:0] b_out;
  logic [1:0]    status;

  // Upstream/downstream side (bench or surrounding datapath)
  modport master (
    output in_valid, s1, s5, s2, out_ready,
    input  in_ready, out_valid, a_out, b_out, status
  );

  // Recovery block side
  modport slave (
    input  in_valid, s1, s5, s2, out_ready,
    output in_ready, out_valid, a_out, b_out, status
  );
endinterface

// File: rtl/operand_recover.sv
// Recovers (a, b) from (a+b, a-b, a*b) mod 2^BW by testing both halving
// candidates on one shared serial shift-add multiplier.
module operand_recover #(
  parameter int unsigned BW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_recover_if.slave bus
);

  localparam int unsigned CW = $clog2(BW);
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_AMBIG  = 2'b01;
  localparam logic [1:0] ST_MISM   = 2'b10;
  localparam logic [1:0] ST_PARITY = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL0, MUL1, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [BW-1:0]   r_a_out;
  logic [BW-1:0]   r_b_out;
  logic [1:0]      r_status;
  logic [BW-2:0]   r_h;
  logic [BW-1:0]   r_b0;
  logic [BW-1:0]   r_b1;
  logic [BW-1:0]   r_s2;
  logic [BW-1:0]   r_mcand;
  logic [BW-1:0]   r_mplier;
  logic [BW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_m0;

  logic            w_accept;
  logic [BW-1:0]   w_sum;
  logic [BW-1:0]   w_a0;
  logic [BW-1:0]   w_a1;
  logic            w_last;
  logic [BW-1:0]   w_acc_next;
  logic            w_match;

  // Candidate generation from the live input triple
  assign w_accept   = r_in_ready & bus.in_valid;
  assign w_sum      = bus.s1 + bus.s5;
  assign w_a0       = {1'b0, w_sum[BW-1:1]};
  assign w_a1       = {1'b1, w_sum[BW-1:1]};
  // One shift-add step; the final step's sum is compared directly so no extra cycle is needed
  assign w_last     = (r_cnt == CW'(BW - 1));
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_match    = (w_acc_next == r_s2);

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.a_out     = r_a_out;
  assign bus.b_out     = r_b_out;
  assign bus.status    = r_status;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept)                      w_next = w_sum[0] ? DONE : MUL0;
      MUL0: if (w_last)                        w_next = MUL1;
      MUL1: if (w_last)                        w_next = DONE;
      DONE: if (r_out_valid && bus.out_ready)  w_next = IDLE;
      default:                                 w_next = IDLE;
    endcase
  end

  // Datapath: candidate latch, serial multiply, result selection and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_status    <= ST_OK;
      r_h         <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_s2        <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_m0        <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_h      <= w_sum[BW-1:1];
            r_b0     <= bus.s1 - w_a0;
            r_b1     <= bus.s1 - w_a1;
            r_s2     <= bus.s2;
            r_mcand  <= w_a0;
            r_mplier <= bus.s1 - w_a0;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_sum[0]) begin
              r_a_out  <= '0;
              r_b_out  <= '0;
              r_status <= ST_PARITY;
            end
          end
        end
        MUL0: begin
          if (w_last) begin
            r_m0     <= w_match;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mcand  <= {1'b1, r_h};
            r_mplier <= r_b1;
          end else begin
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CW'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        MUL1: begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            if (w_match && !r_m0) begin
              r_a_out  <= {1'b1, r_h};
              r_b_out  <= r_b1;
              r_status <= ST_OK;
            end else begin
              r_a_out  <= {1'b0, r_h};
              r_b_out  <= r_b0;
              r_status <= (r_m0 && w_match) ? ST_AMBIG :
                          r_m0              ? ST_OK    : ST_MISM;
            end
          end else begin
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CW'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_recover.sv
// Self-checking bench for operand_recover: directed table, backpressure,
// reset abort and random triples against a brute-force reference.
module tb_operand_recover;

  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_recover_if #(.BW(BW)) bus();

  operand_recover #(.BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s5;
    logic [7:0] s2;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] st;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference: search every a whose implied b = s1-a reproduces s5, then test products
  task automatic model(input logic [7:0] s1, input logic [7:0] s5, input logic [7:0] s2,
                       output logic [7:0] ea, output logic [7:0] eb, output logic [1:0] est);
    int cand[$];
    int hits[$];
    for (int x = 0; x < 256; x++) begin
      logic [7:0] av;
      logic [7:0] bv;
      logic [7:0] dv;
      av = 8'(x);
      bv = s1 - av;
      dv = av - bv;
      if (dv == s5) cand.push_back(x);
    end
    if (cand.size() == 0) begin
      ea = 8'd0; eb = 8'd0; est = 2'b11;
      return;
    end
    foreach (cand[i]) begin
      logic [7:0]  av;
      logic [7:0]  bv;
      logic [15:0] p;
      av = 8'(cand[i]);
      bv = s1 - av;
      p  = av * bv;
      if (p[7:0] == s2) hits.push_back(cand[i]);
    end
    if (hits.size() == 1) begin
      ea = 8'(hits[0]); est = 2'b00;
    end else begin
      ea = 8'(cand[0]); est = (hits.size() == 2) ? 2'b01 : 2'b10;
    end
    eb = s1 - ea;
  endtask

  // Present a triple and return at the falling edge right after the accept edge
  task automatic send(input logic [7:0] s1, input logic [7:0] s5, input logic [7:0] s2);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.s1 = s1; bus.s5 = s5; bus.s2 = s2;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.s1 = 8'($urandom); bus.s5 = 8'($urandom); bus.s2 = 8'($urandom);
  endtask

  // Wait for the result, check latency/values, stall for `hold` cycles, then handshake
  task automatic receive(input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] est,
                         input int elat, input int hold, input string tag);
    int lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    if (!bus.out_valid) return;
    chk({tag, "_a"}, int'(bus.a_out), int'(ea));
    chk({tag, "_b"}, int'(bus.b_out), int'(eb));
    chk({tag, "_status"}, int'(bus.status), int'(est));
    chk({tag, "_in_ready_busy"}, int'(bus.in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_a"}, int'(bus.a_out), int'(ea));
      chk({tag, "_hold_b"}, int'(bus.b_out), int'(eb));
      chk({tag, "_hold_status"}, int'(bus.status), int'(est));
      chk({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_ready_rise"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea, eb, a, b, s1, s5, s2;
    logic [1:0] est;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.s1 = 8'd0; bus.s5 = 8'd0; bus.s2 = 8'd0;

    vecs[0] = '{s1: 8'd9,   s5: 8'd3,   s2: 8'd18,  a: 8'd6,   b: 8'd3, st: 2'b00, lat: 16};
    vecs[1] = '{s1: 8'd207, s5: 8'd193, s2: 8'd120, a: 8'd200, b: 8'd7, st: 2'b00, lat: 16};
    vecs[2] = '{s1: 8'd8,   s5: 8'd2,   s2: 8'd15,  a: 8'd5,   b: 8'd3, st: 2'b01, lat: 16};
    vecs[3] = '{s1: 8'd8,   s5: 8'd2,   s2: 8'd16,  a: 8'd5,   b: 8'd3, st: 2'b10, lat: 16};
    vecs[4] = '{s1: 8'd8,   s5: 8'd3,   s2: 8'd77,  a: 8'd0,   b: 8'd0, st: 2'b11, lat: 0};

    // Reset values
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_a", int'(bus.a_out), 0);
    chk("rst_b", int'(bus.b_out), 0);
    chk("rst_status", int'(bus.status), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      send(vecs[i].s1, vecs[i].s5, vecs[i].s2);
      receive(vecs[i].a, vecs[i].b, vecs[i].st, vecs[i].lat, i, $sformatf("vec%0d", i));
    end

    // Backpressure with a second triple waiting on the input
    send(8'd9, 8'd3, 8'd18);
    bus.in_valid = 1'b1;
    bus.s1 = 8'd207; bus.s5 = 8'd193; bus.s2 = 8'd120;
    receive(8'd6, 8'd3, 2'b00, 16, 5, "bp_first");
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second_accepted", int'(bus.in_ready), 0);
    receive(8'd200, 8'd7, 2'b00, 16, 0, "bp_second");

    // Reset during MUL1 aborts without a result
    send(8'd8, 8'd2, 8'd15);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_status", int'(bus.status), 0);
    chk("abort_a", int'(bus.a_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stale = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.out_valid) stale++;
      end
      chk("abort_no_stale_valid", stale, 0);
    end
    send(8'd207, 8'd193, 8'd120);
    receive(8'd200, 8'd7, 2'b00, 16, 0, "after_abort");

    // Random triples against the reference
    for (int n = 0; n < 40; n++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      s1 = a + b;
      s5 = a - b;
      s2 = 8'(a * b);
      if ($urandom_range(0, 3) == 0) s2 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) s5 = s5 ^ 8'd1;
      model(s1, s5, s2, ea, eb, est);
      send(s1, s5, s2);
      receive(ea, eb, est, (est == 2'b11) ? 0 : 16, int'($urandom_range(0, 2)),
              $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
